// File: rtl/pipe_ctrl_if.sv
// Redirect/stall control bundle between hazard logic
// and the pipeline control unit.
interface pipe_ctrl_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int NSTG = 5
);
  localparam int SW = (NSTG > 1) ? $clog2(NSTG) : 1;

  logic [NSRC-1:0]      rdr_req_i;
  logic [NSRC*XLEN-1:0] rdr_addr_i;
  logic [NSRC*SW-1:0]   rdr_stg_i;
  logic [NSTG-1:0]      stall_req_i;
  logic                 hold_o;
  logic [NSTG-1:0]      flush_o;
  logic [NSTG-1:0]      stall_o;
  logic                 jflag_o;
  logic [XLEN-1:0]      jaddr_o;
  logic [31:0]          rdr_cnt_o;
  logic [31:0]          stall_cnt_o;

  modport master (
    output rdr_req_i, rdr_addr_i, rdr_stg_i, stall_req_i,
    input  hold_o, flush_o, stall_o, jflag_o, jaddr_o,
    input  rdr_cnt_o, stall_cnt_o
  );

  modport slave (
    input  rdr_req_i, rdr_addr_i, rdr_stg_i, stall_req_i,
    output hold_o, flush_o, stall_o, jflag_o, jaddr_o,
    output rdr_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: redirect arbitration, flush/stall
// vectors, fetch hold window and perf counters.
module pipe_ctrl #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int NSTG     = 5,
  parameter int HOLD_CYC = 1
) (
  input  logic  clk,
  input  logic  rst,
  pipe_ctrl_if.slave bus
);
  localparam int SW = (NSTG > 1) ? $clog2(NSTG) : 1;
  localparam logic [3:0] HC = 4'(HOLD_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDIR,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_hold_cnt;
  logic [3:0]      w_hold_nxt;
  logic            r_jflag;
  logic [XLEN-1:0] r_jaddr;
  logic [31:0]     r_rdr_cnt;
  logic [31:0]     r_stall_cnt;

  logic [NSRC-1:0] w_qual;
  logic            w_acc;
  logic [XLEN-1:0] w_addr;
  logic [SW-1:0]   w_stg;
  logic [NSTG-1:0] w_flush;
  logic [NSTG-1:0] w_stall;
  logic            w_run;

  // A source is blocked by any stall request older than its stage
  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      w_qual[k] = bus.rdr_req_i[k];
      for (int t = 0; t < NSTG; t++) begin
        if (bus.stall_req_i[t] &&
            (t > int'(bus.rdr_stg_i[k*SW +: SW])))
          w_qual[k] = 1'b0;
      end
    end
  end

  // Lowest-index qualified source wins
  always_comb begin
    w_acc  = |w_qual;
    w_addr = '0;
    w_stg  = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (w_qual[k]) begin
        w_addr = bus.rdr_addr_i[k*XLEN +: XLEN];
        w_stg  = bus.rdr_stg_i[k*SW +: SW];
      end
    end
  end

  // Flush everything younger than the redirecting stage
  always_comb begin
    w_flush = '0;
    for (int k = 0; k < NSTG; k++) begin
      if (w_acc && (k < int'(w_stg)))
        w_flush[k] = 1'b1;
    end
    if (r_state != S_IDLE)
      w_flush[0] = 1'b1;
  end

  // Stall propagates toward younger stages, masked by flush
  always_comb begin
    w_run   = 1'b0;
    w_stall = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      w_run      = w_run | bus.stall_req_i[k];
      w_stall[k] = w_run & ~w_flush[k];
    end
  end

  // Next-state: any acceptance restarts the redirect
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    unique case (r_state)
      S_IDLE: ;
      S_REDIR: begin
        if (HOLD_CYC == 0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = HC - 4'd1;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == 4'd0)
          w_state_nxt = S_IDLE;
        else
          w_hold_nxt = r_hold_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_acc)
      w_state_nxt = S_REDIR;
  end

  // State, redirect output and saturating counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= 4'd0;
      r_jflag     <= 1'b0;
      r_jaddr     <= '0;
      r_rdr_cnt   <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_jflag    <= w_acc;
      if (w_acc)
        r_jaddr <= w_addr;
      if (w_acc && (r_rdr_cnt != 32'hFFFF_FFFF))
        r_rdr_cnt <= r_rdr_cnt + 32'd1;
      if ((|w_stall) && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.hold_o      = !rst || (|w_qual) ||
                           (r_state != S_IDLE);
  assign bus.flush_o     = w_flush;
  assign bus.stall_o     = w_stall;
  assign bus.jflag_o     = r_jflag;
  assign bus.jaddr_o     = r_jaddr;
  assign bus.rdr_cnt_o   = r_rdr_cnt;
  assign bus.stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table plus
// multi-cycle redirect, pre-emption and reset sequences.
module tb_pipe_ctrl;
  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] a0, a1;
  logic [2:0]  g0, g1;
  logic [4:0]  sreq;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl_if #(.XLEN(32), .NSRC(2), .NSTG(5)) b1 ();
  pipe_ctrl_if #(.XLEN(32), .NSRC(2), .NSTG(5)) b3 ();

  assign b1.rdr_req_i   = req;
  assign b1.rdr_addr_i  = {a1, a0};
  assign b1.rdr_stg_i   = {g1, g0};
  assign b1.stall_req_i = sreq;
  assign b3.rdr_req_i   = req;
  assign b3.rdr_addr_i  = {a1, a0};
  assign b3.rdr_stg_i   = {g1, g0};
  assign b3.stall_req_i = sreq;

  pipe_ctrl #(.XLEN(32), .NSRC(2), .NSTG(5), .HOLD_CYC(1))
    u_d1 (.clk(clk), .rst(rst), .bus(b1));
  pipe_ctrl #(.XLEN(32), .NSRC(2), .NSTG(5), .HOLD_CYC(3))
    u_d3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    req  = 2'b00;
    sreq = 5'b00000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [2:0]  g0;
    logic [2:0]  g1;
    logic [4:0]  sreq;
    logic [4:0]  flush;
    logic [4:0]  stall;
    logic        hold;
    logic        jf;
    logic [31:0] ja;
  } vec_t;

  vec_t vt[9];
  int   e_rc;
  int   e_sc;
  logic [31:0] e_ja;

  initial begin
    vt[0] = '{2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'b00000,
              5'b00000, 5'b00000, 1'b0, 1'b0, 32'h0};
    vt[1] = '{2'b10, 32'h0,   32'h100, 3'd0, 3'd2, 5'b00000,
              5'b00011, 5'b00000, 1'b1, 1'b1, 32'h100};
    vt[2] = '{2'b11, 32'h200, 32'h100, 3'd3, 3'd2, 5'b00000,
              5'b00111, 5'b00000, 1'b1, 1'b1, 32'h200};
    vt[3] = '{2'b10, 32'h0,   32'h120, 3'd0, 3'd2, 5'b01000,
              5'b00000, 5'b01111, 1'b0, 1'b0, 32'h0};
    vt[4] = '{2'b10, 32'h0,   32'h130, 3'd0, 3'd2, 5'b00100,
              5'b00011, 5'b00100, 1'b1, 1'b1, 32'h130};
    vt[5] = '{2'b10, 32'h0,   32'h150, 3'd0, 3'd2, 5'b00010,
              5'b00011, 5'b00000, 1'b1, 1'b1, 32'h150};
    vt[6] = '{2'b11, 32'h200, 32'h400, 3'd1, 3'd4, 5'b00100,
              5'b01111, 5'b00000, 1'b1, 1'b1, 32'h400};
    vt[7] = '{2'b00, 32'h0,   32'h0,   3'd0, 3'd0, 5'b10000,
              5'b00000, 5'b11111, 1'b0, 1'b0, 32'h0};
    vt[8] = '{2'b01, 32'h80,  32'h0,   3'd0, 3'd0, 5'b00000,
              5'b00000, 5'b00000, 1'b1, 1'b1, 32'h80};

    rst = 1'b1;
    req = 2'b00; sreq = 5'b00000;
    a0 = '0; a1 = '0; g0 = '0; g1 = '0;
    e_rc = 0; e_sc = 0; e_ja = 32'h0;

    #2 rst = 1'b0;
    #1;
    chk("rst_jflag", 32'(b1.jflag_o), 32'd0);
    chk("rst_jaddr", b1.jaddr_o, 32'd0);
    chk("rst_rcnt", b1.rdr_cnt_o, 32'd0);
    chk("rst_scnt", b1.stall_cnt_o, 32'd0);
    chk("rst_hold", 32'(b1.hold_o), 32'd1);
    chk("rst_flush", 32'(b1.flush_o), 32'd0);
    chk("rst_hold3", 32'(b3.hold_o), 32'd1);
    step();
    step();
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      req = vt[i].req; a0 = vt[i].a0; a1 = vt[i].a1;
      g0 = vt[i].g0; g1 = vt[i].g1; sreq = vt[i].sreq;
      #1;
      chk($sformatf("v%0d_flush", i), 32'(b1.flush_o),
          32'(vt[i].flush));
      chk($sformatf("v%0d_stall", i), 32'(b1.stall_o),
          32'(vt[i].stall));
      chk($sformatf("v%0d_hold", i), 32'(b1.hold_o),
          32'(vt[i].hold));
      if (vt[i].jf) begin
        e_rc++;
        e_ja = vt[i].ja;
      end
      if (vt[i].stall != 5'b0)
        e_sc++;
      step();
      clr();
      chk($sformatf("v%0d_jflag", i), 32'(b1.jflag_o),
          32'(vt[i].jf));
      chk($sformatf("v%0d_jaddr", i), b1.jaddr_o, e_ja);
      chk($sformatf("v%0d_jaddr3", i), b3.jaddr_o, e_ja);
      chk($sformatf("v%0d_rcnt", i), b1.rdr_cnt_o, 32'(e_rc));
      chk($sformatf("v%0d_scnt", i), b1.stall_cnt_o, 32'(e_sc));
      if (vt[i].jf) begin
        #1;
        chk($sformatf("v%0d_hold1", i), 32'(b1.hold_o), 32'd1);
        step();
        chk($sformatf("v%0d_hold2", i), 32'(b1.hold_o), 32'd1);
        step();
        chk($sformatf("v%0d_hold3", i), 32'(b1.hold_o), 32'd0);
      end
      repeat (5) step();
    end

    req = 2'b10; g1 = 3'd2; a1 = 32'h140; sreq = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("sb_stall", 32'(b1.stall_o), 32'b01111);
      chk("sb_hold", 32'(b1.hold_o), 32'd0);
      e_sc++;
      step();
      chk("sb_jflag", 32'(b1.jflag_o), 32'd0);
    end
    sreq = 5'b00000;
    #1;
    chk("sb_flush", 32'(b1.flush_o), 32'b00011);
    chk("sb_hold_acc", 32'(b1.hold_o), 32'd1);
    e_rc++;
    step();
    clr();
    chk("sb_jflag_acc", 32'(b1.jflag_o), 32'd1);
    chk("sb_jaddr", b1.jaddr_o, 32'h140);
    chk("sb_scnt", b1.stall_cnt_o, 32'(e_sc));
    chk("sb_rcnt", b1.rdr_cnt_o, 32'(e_rc));
    repeat (6) step();

    req = 2'b10; g1 = 3'd2; a1 = 32'h100;
    step();
    clr();
    chk("pe_jflag1", 32'(b3.jflag_o), 32'd1);
    chk("pe_jaddr1", b3.jaddr_o, 32'h100);
    step();
    chk("pe_cnt1", 32'(u_d3.r_hold_cnt), 32'd2);
    chk("pe_jflag_h", 32'(b3.jflag_o), 32'd0);
    req = 2'b01; g0 = 3'd3; a0 = 32'h300;
    #1;
    chk("pe_flush", 32'(b3.flush_o), 32'b00111);
    step();
    clr();
    chk("pe_jflag2", 32'(b3.jflag_o), 32'd1);
    chk("pe_jaddr2", b3.jaddr_o, 32'h300);
    step();
    chk("pe_cnt2", 32'(u_d3.r_hold_cnt), 32'd2);
    chk("pe_hold_a", 32'(b3.hold_o), 32'd1);
    step();
    chk("pe_hold_b", 32'(b3.hold_o), 32'd1);
    step();
    chk("pe_hold_c", 32'(b3.hold_o), 32'd1);
    step();
    chk("pe_hold_d", 32'(b3.hold_o), 32'd0);
    chk("pe_jflag_d", 32'(b3.jflag_o), 32'd0);
    e_rc += 2;
    chk("pe_rcnt", b1.rdr_cnt_o, 32'(e_rc));
    repeat (3) step();

    force u_d1.r_rdr_cnt = 32'hFFFF_FFFE;
    force u_d1.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release u_d1.r_rdr_cnt;
    release u_d1.r_stall_cnt;
    req = 2'b10; g1 = 3'd4; a1 = 32'h400; sreq = 5'b10000;
    #1;
    chk("sat_stall", 32'(b1.stall_o), 32'b10000);
    chk("sat_flush", 32'(b1.flush_o), 32'b01111);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("sat_rcnt%0d", c), b1.rdr_cnt_o,
          32'hFFFF_FFFF);
      chk($sformatf("sat_scnt%0d", c), b1.stall_cnt_o,
          32'hFFFF_FFFF);
    end
    clr();
    repeat (6) step();

    req = 2'b10; g1 = 3'd2; a1 = 32'h180;
    step();
    clr();
    chk("ar_jflag_pre", 32'(b3.jflag_o), 32'd1);
    step();
    #2 rst = 1'b0;
    #1;
    chk("ar_jflag", 32'(b3.jflag_o), 32'd0);
    chk("ar_jaddr", b3.jaddr_o, 32'd0);
    chk("ar_rcnt", b3.rdr_cnt_o, 32'd0);
    chk("ar_scnt", b3.stall_cnt_o, 32'd0);
    chk("ar_hold", 32'(b3.hold_o), 32'd1);
    chk("ar_rcnt1", b1.rdr_cnt_o, 32'd0);
    chk("ar_jaddr1", b1.jaddr_o, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("ar_hold_post", 32'(b3.hold_o), 32'd0);
    chk("ar_hold_post1", 32'(b1.hold_o), 32'd0);
    chk("ar_flush_post", 32'(b3.flush_o), 32'd0);
    chk("ar_jflag_post", 32'(b3.jflag_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order RISC-V core. It arbitrates several prioritised redirect sources (e.g. trap, EX jump/branch) and turns the winner into a registered PC redirect. It generates per-stage flush and stall vectors and holds fetch through a configurable refill window. It also keeps saturating redirect and stall-cycle counters for performance monitoring. It sits between the execute/CSR/hazard-detect logic and the PC/fetch stage.

## Interface
Parameters:
- XLEN, 32, address width
- NSRC, 2, number of redirect sources; index 0 has highest priority
- NSTG, 5, pipeline stages; stage 0 = IF (youngest), NSTG-1 = WB (oldest)
- HOLD_CYC, 1, extra fetch-hold cycles after a redirect is issued (0..15)
- SW (localparam), $clog2(NSTG), stage-index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- rdr_req_i  in  NSRC  redirect request per source
- rdr_addr_i  in  NSRC*XLEN  target address; source k at [k*XLEN +: XLEN]
- rdr_stg_i  in  NSRC*SW  originating stage of source k at [k*SW +: SW]
- stall_req_i  in  NSTG  stall request per stage
- hold_o  out  1  fetch hold (combinational)
- flush_o  out  NSTG  per-stage flush (combinational)
- stall_o  out  NSTG  per-stage stall (combinational)
- jflag_o  out  1  registered redirect valid to PC
- jaddr_o  out  XLEN  registered redirect target
- rdr_cnt_o  out  32  accepted-redirect count, saturating
- stall_cnt_o  out  32  cycles with any stall_o bit set, saturating

## Operation
- Qualification: source k is qualified iff rdr_req_i[k]=1 and no stall_req_i[t]=1 for any t > rdr_stg_i[k]. A stalled older instruction blocks a redirect from a younger one.
- Arbitration: the winner is the lowest-index qualified source. At most one redirect is accepted per cycle.
- flush_o: for an accepted redirect from stage s, bits [s-1:0] are 1 and the originating stage is not flushed. flush_o[0]=1 additionally while state != IDLE.
- stall_o[k] = OR of stall_req_i[NSTG-1:k], forced 0 wherever flush_o[k]=1.
- hold_o = !rst | any qualified request | state != IDLE.
- State machine:
  - IDLE: on an accepted redirect, go to REDIR.
  - REDIR: jflag_o=1 for exactly this cycle. Next state is HOLD, loading hold_cnt=HOLD_CYC-1, or IDLE if HOLD_CYC=0.
  - HOLD: decrement hold_cnt each cycle; go to IDLE after the cycle with hold_cnt=0.
  - An accepted redirect in any state (REDIR, HOLD included) re-enters REDIR with the new target. This lets a trap from an older stage pre-empt a refill.
- jaddr_o loads the winner's address on acceptance and holds its value otherwise. jflag_o is registered: 1 iff a redirect was accepted on the previous edge.
- Counters: rdr_cnt_o increments on each accepted redirect. stall_cnt_o increments each cycle with |stall_o. Both stick at 32'hFFFF_FFFF.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, hold_cnt=0, jflag_o=0, jaddr_o=0, both counters=0.
- During reset, hold_o=1, and flush_o/stall_o follow the combinational rules.
- After reset deassertion, the first edge operates normally.
- Redirect accepted at edge N-1 → jflag_o=1 and jaddr_o valid during cycle N → hold_o stays 1 through cycle N+HOLD_CYC.
- hold_o, flush_o and stall_o respond in the same cycle as their inputs; there is no registered path.
- Simultaneous redirect and stall at the same or a younger stage: the redirect is accepted, and the flushed stages have their stall masked.
- Reset asserted mid-HOLD: returns immediately to IDLE and clears all outputs; the pending redirect is lost.

## Test plan
- Single redirect: NSTG=5, HOLD_CYC=1, source 1 at stage 2, addr 0x0000_0100 for one cycle.
  - Same cycle: flush_o=5'b00011, hold_o=1.
  - Next cycle: jflag_o=1, jaddr_o=0x100.
  - hold_o stays 1 for 2 cycles after acceptance; rdr_cnt_o=1.
- Priority: sources 0 (stg 3, 0x200) and 1 (stg 2, 0x100) both request in the same cycle → jaddr_o=0x200, flush_o=5'b00111, rdr_cnt_o=1.
- Stall blocking: stall_req_i[3]=1 with source 1 at stage 2.
  - While stalled: no acceptance, stall_o=5'b01111, jflag_o stays 0.
  - Cycle after the stall drops: redirect accepted; stall_cnt_o counts the stalled cycles.
- Pre-emption: HOLD_CYC=3, redirect to 0x100; in the first HOLD cycle, source 0 redirects to 0x300 → jflag_o pulses again with 0x300, hold_cnt restarts at 2.
- Saturation: force both counters to 0xFFFF_FFFE, then apply 3 redirect and stall events → both read 0xFFFF_FFFF.
- Async reset mid-HOLD: drop rst between edges → jflag_o=0, jaddr_o=0, counters 0, hold_o=1 immediately. After release with no requests, hold_o=0 on the next cycle.
